// File: rtl/command_decoder_pkg.sv
// Shared definitions for the command decoder: opcodes, argument counts,
// FSM state encoding and framebuffer/colour widths.
package command_decoder_pkg;

  localparam int CLEAR_COLOR_WIDTH = 12;
  localparam int FB_ADDRESS_WIDTH  = 22;

  localparam logic [7:0] OP_NOP               = 8'h00;
  localparam logic [7:0] OP_CLEAR_ERROR       = 8'h01;
  localparam logic [7:0] OP_START_VGA         = 8'h02;
  localparam logic [7:0] OP_STOP_VGA          = 8'h03;
  localparam logic [7:0] OP_SET_WRITE_ADDRESS = 8'h04;
  localparam logic [7:0] OP_CLEAR             = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_VGA_RESET = 3'd3,
    ST_VGA_WAIT  = 3'd4
  } state_t;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_WRITE_ADDRESS: return 2'd3;
      OP_CLEAR:             return 2'd2;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_known_opcode(input logic [7:0] op);
    return op <= OP_CLEAR;
  endfunction

endpackage

// File: rtl/command_decoder_collector.sv
// Little-endian argument assembler for the command decoder. The idle-gap
// timeout counter is only built when COMMAND_TIMEOUT_EN is defined.
module command_argument_collector #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  count,
  input  logic        collecting,
  input  logic        byte_valid,
  input  logic [7:0]  arg_byte,
  output logic        args_done,
  output logic [23:0] args_value,
  output logic        timeout
);

  logic [1:0] count_q;
  logic [1:0] index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      index      <= '0;
      args_value <= '0;
    end else begin
      if (start) count_q <= count;
      // A new opcode or an abort discards any partially assembled value.
      if (start || timeout) begin
        index      <= '0;
        args_value <= '0;
      end else if (byte_valid) begin
        args_value[{index, 3'b000} +: 8] <= arg_byte;
        index <= index + 2'd1;
      end
    end
  end

  assign args_done = byte_valid && (index == count_q - 2'd1);

`ifdef COMMAND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_count <= '0;
    end else if (start || byte_valid || !collecting) begin
      idle_count <= '0;
    end else begin
      idle_count <= idle_count + TW'(1);
    end
  end

  assign timeout = collecting && !byte_valid && (idle_count == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = collecting ^ (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/command_decoder.sv
// Byte command interpreter driving VGA bring-up, framebuffer write address and
// clear colour. COMMAND_TIMEOUT_EN enables the argument-gap timeout.
module command_decoder
  import command_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         system_clock,
  input  logic                         reset,
  input  logic                         command_strobe,
  input  logic [7:0]                   command_byte,
  output logic                         command_ready,
  output logic                         vga_reset,
  output logic                         vga_enable,
  output logic [FB_ADDRESS_WIDTH-1:0]  write_address,
  output logic                         write_address_load,
  output logic [CLEAR_COLOR_WIDTH-1:0] clear_color,
  output logic                         clear_start,
  output logic                         error,
  output state_t                       debug_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t        state, state_next;
  logic [7:0]    opcode;
  logic [SW-1:0] settle_count;
  logic          collect_start, byte_valid, args_done, timeout;
  logic [23:0]   args_value;
  logic          accept, settle_done, bad_opcode, overrun;
  logic          unused_args;

  // command_strobe is a one-cycle valid; the byte is taken only while
  // command_ready is high, otherwise it is dropped and flagged in error.
  assign accept      = command_strobe && command_ready;
  assign overrun     = command_strobe && !command_ready;
  assign bad_opcode  = (state == ST_IDLE) && accept && !is_known_opcode(command_byte);
  assign settle_done = (state == ST_VGA_WAIT) && (settle_count == SW'(SETTLE_CYCLES - 1));
  assign debug_state = state;
  assign unused_args = ^args_value[23:22];

  command_argument_collector #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_collector (
    .clk        (system_clock),
    .rst        (reset),
    .start      (collect_start),
    .count      (arg_count(command_byte)),
    .collecting (state == ST_COLLECT),
    .byte_valid (byte_valid),
    .arg_byte   (command_byte),
    .args_done  (args_done),
    .args_value (args_value),
    .timeout    (timeout)
  );

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    collect_start = 1'b0;
    byte_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_known_opcode(command_byte)) begin
          if (arg_count(command_byte) == 2'd0) begin
            state_next = ST_EXECUTE;
          end else begin
            state_next    = ST_COLLECT;
            collect_start = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        byte_valid = accept;
        if (args_done)    state_next = ST_EXECUTE;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_EXECUTE:   state_next = (opcode == OP_START_VGA) ? ST_VGA_RESET : ST_IDLE;
      ST_VGA_RESET: state_next = ST_VGA_WAIT;
      ST_VGA_WAIT:  if (settle_done) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the state being left, so every action
  // appears one edge after the cycle that decides it.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      command_ready      <= 1'b0;
      vga_reset          <= 1'b0;
      vga_enable         <= 1'b0;
      write_address      <= '0;
      write_address_load <= 1'b0;
      clear_color        <= '0;
      clear_start        <= 1'b0;
      error              <= 1'b0;
      opcode             <= '0;
      settle_count       <= '0;
    end else begin
      command_ready      <= (state_next == ST_IDLE) || (state_next == ST_COLLECT);
      vga_reset          <= (state == ST_VGA_RESET);
      write_address_load <= 1'b0;
      clear_start        <= 1'b0;
      settle_count       <= (state == ST_VGA_WAIT) ? settle_count + SW'(1) : '0;
      if ((state == ST_IDLE) && accept) opcode <= command_byte;
      if (state == ST_EXECUTE) begin
        case (opcode)
          OP_CLEAR_ERROR: error <= 1'b0;
          OP_START_VGA:   vga_enable <= 1'b0;
          OP_STOP_VGA:    vga_enable <= 1'b0;
          OP_SET_WRITE_ADDRESS: begin
            write_address      <= args_value[FB_ADDRESS_WIDTH-1:0];
            write_address_load <= 1'b1;
          end
          OP_CLEAR: begin
            clear_color <= args_value[CLEAR_COLOR_WIDTH-1:0];
            clear_start <= 1'b1;
          end
          default: ;
        endcase
      end
      if (settle_done) vga_enable <= 1'b1;
      // A fresh fault wins over a simultaneous CLEAR_ERROR.
      if (bad_opcode || overrun || timeout) error <= 1'b1;
    end
  end

endmodule
